// File: rtl/atari_pkg.sv
// Shared definitions for the object mixer and collision latch:
// collision register indices, CTRLPF bit positions, colour and object types.
package atari_pkg;

    localparam int CX_M0P  = 0;
    localparam int CX_M1P  = 1;
    localparam int CX_P0FB = 2;
    localparam int CX_P1FB = 3;
    localparam int CX_M0FB = 4;
    localparam int CX_M1FB = 5;
    localparam int CX_BLPF = 6;
    localparam int CX_PPMM = 7;

    localparam int CTRLPF_SCORE = 1;
    localparam int CTRLPF_PFP   = 2;

    typedef logic [6:0] color_t;

    typedef struct packed {
        logic p0;
        logic p1;
        logic m0;
        logic m1;
        logic bl;
        logic pf;
    } obj_t;

endpackage

// File: rtl/collision_latch.sv
// Fifteen sticky collision flags with clear/set ordering and registered
// indexed read.
// Ports: raw_clk, reset (sync, high), i_clear strobe, i_obj stage-A object
// bits, i_index read select, o_data {flag7, flag6, 6'b0}.
module collision_latch
    import atari_pkg::*;
(
    input  logic       raw_clk,
    input  logic       reset,
    input  logic       i_clear,
    input  obj_t       i_obj,
    input  logic [2:0] i_index,
    output logic [7:0] o_data
);

    logic [7:0][1:0] r_cx;
    logic [7:0][1:0] w_set;
    logic [7:0]      r_data;

    always_comb begin
        w_set          = '0;
        w_set[CX_M0P]  = {i_obj.m0 & i_obj.p1, i_obj.m0 & i_obj.p0};
        w_set[CX_M1P]  = {i_obj.m1 & i_obj.p0, i_obj.m1 & i_obj.p1};
        w_set[CX_P0FB] = {i_obj.p0 & i_obj.pf, i_obj.p0 & i_obj.bl};
        w_set[CX_P1FB] = {i_obj.p1 & i_obj.pf, i_obj.p1 & i_obj.bl};
        w_set[CX_M0FB] = {i_obj.m0 & i_obj.pf, i_obj.m0 & i_obj.bl};
        w_set[CX_M1FB] = {i_obj.m1 & i_obj.pf, i_obj.m1 & i_obj.bl};
        w_set[CX_BLPF] = {i_obj.bl & i_obj.pf, 1'b0};
        w_set[CX_PPMM] = {i_obj.p0 & i_obj.p1, i_obj.m0 & i_obj.m1};
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            r_cx   <= '0;
            r_data <= '0;
        end else begin
            // Clear first, then OR in this cycle's collisions so a
            // simultaneous hit is never lost.
            r_cx   <= (i_clear ? '0 : r_cx) | w_set;
            r_data <= {r_cx[i_index], 6'b0};
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/collision_mixer.sv
// Per-pixel object priority mixer feeding HDMI plus collision latch.
// Ports: raw_clk/reset, object bits and colour registers in; color,
// color_valid out (2-edge latency); cx_clear/cx_index in, cx_data out.
module collision_mixer
    import atari_pkg::*;
#(
    parameter int COLOR_BITS = 7
) (
    input  logic                  raw_clk,
    input  logic                  reset,
    input  logic                  in_image,
    input  logic                  pos_x_right,
    input  logic                  p0,
    input  logic                  p1,
    input  logic                  m0,
    input  logic                  m1,
    input  logic                  bl,
    input  logic                  pf,
    input  logic [COLOR_BITS-1:0] color_p0,
    input  logic [COLOR_BITS-1:0] color_p1,
    input  logic [COLOR_BITS-1:0] color_fg,
    input  logic [COLOR_BITS-1:0] color_bg,
    input  logic [2:0]            ctrlpf,
    input  logic                  cx_clear,
    input  logic [2:0]            cx_index,
    output logic [7:0]            cx_data,
    output logic [COLOR_BITS-1:0] color,
    output logic                  color_valid
);

    obj_t                  r_obj;
    logic                  r_in;
    logic                  r_right;
    logic                  r_score;
    logic                  r_pfp;
    logic [COLOR_BITS-1:0] r_cp0;
    logic [COLOR_BITS-1:0] r_cp1;
    logic [COLOR_BITS-1:0] r_cfg;
    logic [COLOR_BITS-1:0] r_cbg;

    logic [COLOR_BITS-1:0] r_color;
    logic                  r_valid;

    logic [COLOR_BITS-1:0] w_pfc;
    logic [COLOR_BITS-1:0] w_color;
    logic                  w_g0;
    logic                  w_g1;
    logic                  w_gpf;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            r_obj   <= '0;
            r_in    <= 1'b0;
            r_right <= 1'b0;
            r_score <= 1'b0;
            r_pfp   <= 1'b0;
            r_cp0   <= '0;
            r_cp1   <= '0;
            r_cfg   <= '0;
            r_cbg   <= '0;
        end else begin
            r_obj   <= {p0, p1, m0, m1, bl, pf} & {6{in_image}};
            r_in    <= in_image;
            r_right <= pos_x_right;
            r_score <= ctrlpf[CTRLPF_SCORE];
            r_pfp   <= ctrlpf[CTRLPF_PFP];
            r_cp0   <= color_p0;
            r_cp1   <= color_p1;
            r_cfg   <= color_fg;
            r_cbg   <= color_bg;
        end
    end

    always_comb begin
        w_g0  = r_obj.p0 | r_obj.m0;
        w_g1  = r_obj.p1 | r_obj.m1;
        w_gpf = r_obj.bl | r_obj.pf;
        // Ball is always foreground; playfield follows score-mode halves.
        w_pfc = r_cfg;
        if (!r_obj.bl && r_score)
            w_pfc = r_right ? r_cp1 : r_cp0;
        w_color = r_cbg;
        if (!r_in)
            w_color = '0;
        else if (r_pfp && w_gpf)
            w_color = w_pfc;
        else if (w_g0)
            w_color = r_cp0;
        else if (w_g1)
            w_color = r_cp1;
        else if (w_gpf)
            w_color = w_pfc;
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            r_color <= '0;
            r_valid <= 1'b0;
        end else begin
            r_color <= w_color;
            r_valid <= r_in;
        end
    end

    assign color       = r_color;
    assign color_valid = r_valid;

    collision_latch u_cx (
        .raw_clk (raw_clk),
        .reset   (reset),
        .i_clear (cx_clear),
        .i_obj   (r_obj),
        .i_index (cx_index),
        .o_data  (cx_data)
    );

endmodule

// File: tb/tb_collision_mixer.sv
// Directed table-driven bench for collision_mixer: priority, score mode,
// collision set/read latency, clear-versus-set, reset flush.
module tb_collision_mixer;

    logic       raw_clk = 1'b0;
    logic       reset;
    logic       in_image;
    logic       pos_x_right;
    logic       p0, p1, m0, m1, bl, pf;
    logic [6:0] color_p0, color_p1, color_fg, color_bg;
    logic [2:0] ctrlpf;
    logic       cx_clear;
    logic [2:0] cx_index;
    logic [7:0] cx_data;
    logic [6:0] color;
    logic       color_valid;

    int errors = 0;
    int checks = 0;

    always #5 raw_clk = ~raw_clk;

    collision_mixer #(.COLOR_BITS(7)) dut (
        .raw_clk     (raw_clk),
        .reset       (reset),
        .in_image    (in_image),
        .pos_x_right (pos_x_right),
        .p0          (p0),
        .p1          (p1),
        .m0          (m0),
        .m1          (m1),
        .bl          (bl),
        .pf          (pf),
        .color_p0    (color_p0),
        .color_p1    (color_p1),
        .color_fg    (color_fg),
        .color_bg    (color_bg),
        .ctrlpf      (ctrlpf),
        .cx_clear    (cx_clear),
        .cx_index    (cx_index),
        .cx_data     (cx_data),
        .color       (color),
        .color_valid (color_valid)
    );

    typedef struct {
        logic       img;
        logic       right;
        logic [5:0] obj;
        logic [6:0] cp0;
        logic [6:0] cp1;
        logic [6:0] cfg;
        logic [6:0] cbg;
        logic [2:0] ctrl;
        logic [6:0] exp_c;
        logic       exp_v;
    } vec_t;

    vec_t tv[13];

    task automatic step();
        @(posedge raw_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_obj(input logic [5:0] o);
        {p0, p1, m0, m1, bl, pf} = o;
    endtask

    task automatic clear_flags();
        set_obj(6'b0);
        step();
        step();
        cx_clear = 1'b1;
        step();
        cx_clear = 1'b0;
        step();
    endtask

    initial begin
        // obj order: {p0,p1,m0,m1,bl,pf}
        tv[0]  = '{1, 0, 6'b100001, 7'h12, 7'h56, 7'h34, 7'h78, 3'd0, 7'h12, 1};
        tv[1]  = '{1, 0, 6'b100001, 7'h12, 7'h56, 7'h34, 7'h78, 3'd4, 7'h34, 1};
        tv[2]  = '{1, 0, 6'b000001, 7'h11, 7'h22, 7'h34, 7'h78, 3'd2, 7'h11, 1};
        tv[3]  = '{1, 1, 6'b000001, 7'h11, 7'h22, 7'h34, 7'h78, 3'd2, 7'h22, 1};
        tv[4]  = '{1, 0, 6'b000000, 7'h12, 7'h56, 7'h34, 7'h78, 3'd0, 7'h78, 1};
        tv[5]  = '{1, 0, 6'b010010, 7'h12, 7'h56, 7'h34, 7'h78, 3'd0, 7'h56, 1};
        tv[6]  = '{1, 0, 6'b010010, 7'h12, 7'h56, 7'h34, 7'h78, 3'd4, 7'h34, 1};
        tv[7]  = '{1, 0, 6'b001100, 7'h12, 7'h56, 7'h34, 7'h78, 3'd4, 7'h12, 1};
        tv[8]  = '{1, 0, 6'b000100, 7'h12, 7'h56, 7'h34, 7'h78, 3'd0, 7'h56, 1};
        tv[9]  = '{1, 1, 6'b000010, 7'h11, 7'h22, 7'h34, 7'h78, 3'd2, 7'h34, 1};
        tv[10] = '{0, 0, 6'b111111, 7'h12, 7'h56, 7'h34, 7'h78, 3'd0, 7'h00, 0};
        tv[11] = '{1, 0, 6'b000001, 7'h12, 7'h56, 7'h34, 7'h78, 3'd1, 7'h34, 1};
        tv[12] = '{1, 0, 6'b010001, 7'h11, 7'h22, 7'h34, 7'h78, 3'd6, 7'h11, 1};

        // Reset with random inputs
        reset       = 1'b1;
        in_image    = 1'($urandom);
        pos_x_right = 1'($urandom);
        set_obj(6'($urandom));
        color_p0    = 7'($urandom);
        color_p1    = 7'($urandom);
        color_fg    = 7'($urandom);
        color_bg    = 7'($urandom);
        ctrlpf      = 3'($urandom);
        cx_clear    = 1'($urandom);
        cx_index    = 3'd0;
        step();
        step();
        check("reset_color", {1'b0, color}, 8'h00);
        check("reset_valid", {7'b0, color_valid}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cx_index = 3'(i);
            step();
            check($sformatf("reset_cx%0d", i), cx_data, 8'h00);
        end
        in_image    = 1'b0;
        pos_x_right = 1'b0;
        set_obj(6'b0);
        ctrlpf      = 3'd0;
        cx_clear    = 1'b0;
        reset       = 1'b0;
        step();
        check("post_reset_color", {1'b0, color}, 8'h00);

        // Priority table
        for (int i = 0; i < 13; i++) begin
            in_image    = tv[i].img;
            pos_x_right = tv[i].right;
            set_obj(tv[i].obj);
            color_p0    = tv[i].cp0;
            color_p1    = tv[i].cp1;
            color_fg    = tv[i].cfg;
            color_bg    = tv[i].cbg;
            ctrlpf      = tv[i].ctrl;
            step();
            step();
            check($sformatf("vec%0d_color", i), {1'b0, color},
                  {1'b0, tv[i].exp_c});
            check($sformatf("vec%0d_valid", i), {7'b0, color_valid},
                  {7'b0, tv[i].exp_v});
        end

        // Collision M0*P1 with exact read latency
        in_image = 1'b1;
        ctrlpf   = 3'd0;
        clear_flags();
        cx_index = 3'd0;
        step();
        check("cx0_before", cx_data, 8'h00);
        set_obj(6'b011000);
        step();
        set_obj(6'b0);
        step();
        check("cx0_lat1", cx_data, 8'h00);
        step();
        check("cx0_lat2", cx_data, 8'h80);
        for (int i = 1; i < 8; i++) begin
            cx_index = 3'(i);
            step();
            check($sformatf("cx_other%0d", i), cx_data, 8'h00);
        end

        // Clear versus set
        clear_flags();
        cx_index = 3'd7;
        set_obj(6'b110000);
        step();
        set_obj(6'b0);
        step();
        step();
        step();
        check("ppmm_p0p1", cx_data, 8'h80);
        set_obj(6'b001100);
        cx_clear = 1'b1;
        step();
        set_obj(6'b0);
        cx_clear = 1'b0;
        step();
        step();
        step();
        check("ppmm_clear_set", cx_data, 8'h40);

        // Clear coinciding with a collision already in stage A
        clear_flags();
        set_obj(6'b000011);
        step();
        set_obj(6'b0);
        cx_clear = 1'b1;
        cx_index = 3'd6;
        step();
        cx_clear = 1'b0;
        step();
        step();
        check("blpf_clear_same", cx_data, 8'h80);

        // Reset mid-frame flushes both stages
        set_obj(6'b0);
        color_bg = 7'h78;
        step();
        step();
        step();
        check("run_bg", {1'b0, color}, 8'h78);
        reset = 1'b1;
        step();
        check("midrst_edge1", {1'b0, color}, 8'h00);
        reset = 1'b0;
        step();
        check("midrst_edge2", {1'b0, color}, 8'h00);
        step();
        check("midrst_resume", {1'b0, color}, 8'h78);

        // Outside image for 100 cycles
        clear_flags();
        in_image = 1'b0;
        set_obj(6'b111111);
        step();
        step();
        for (int i = 0; i < 100; i++) begin
            step();
            if (color !== 7'h00 || color_valid !== 1'b0)
                check("out_img", {color_valid, color}, 8'h00);
        end
        check("out_img_color", {1'b0, color}, 8'h00);
        check("out_img_valid", {7'b0, color_valid}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cx_index = 3'(i);
            step();
            check($sformatf("out_img_cx%0d", i), cx_data, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
